mips_mem_arbiter: RTL and testbench

Single-port memory arbiter for the MIPS32 core: shares one synchronous memory between the instruction-fetch requester and the load/store (data) requester. Sits between `MipsProcessor`'s fetch/memory stages and the unified instruction/data RAM, sequences each access through a three-cycle grant/issue/ack FSM and produces per-requester stall signals for the pipeline.

---
 rtl/mips_mem_arbiter.sv | 116 +++++++++++
 tb/tb_mips_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter sharing one synchronous RAM between instruction fetch and load/store.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate grants on ties (default: data always wins ties).
module mips_mem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for a request; winner latched on the way out
    // ISSUE | memory strobed with the latched access
    // ACK   | owner acked, read data forwarded from memory
    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    state_t            state_q;
    logic              owner_q;        // 1 = data requester owns the access
    logic              we_q;
    logic              last_grant_q;   // 1 = data was granted last
    logic              if_ack_q;
    logic              d_ack_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              grant_data_d;

    always_comb begin
        grant_data_d = d_req;
        if (d_req && if_req) begin
            grant_data_d = RR_EN ? ~last_grant_q : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            last_grant_q <= 1'b0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner_q     <= grant_data_d;
                        we_q        <= grant_data_d & d_we;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_data_d & d_we;
                        mem_addr_q  <= grant_data_d ? d_addr : if_addr;
                        mem_wdata_q <= grant_data_d ? d_wdata : '0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if_ack_q <= ~owner_q;
                    d_ack_q  <= owner_q;
                    state_q  <= ACK;
                end
                ACK: begin
                    last_grant_q <= owner_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory read data arrives in ACK, so the rdata mux is combinational off the ack flops.
    assign if_rdata  = if_ack_q ? mem_rdata : '0;
    assign d_rdata   = (d_ack_q && !we_q) ? mem_rdata : '0;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign d_stall   = d_req & ~d_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed vector table, tie/reset sequences,
// then random traffic checked against a transaction-level arbiter and memory model.
module tb_mips_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [8:0]  if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [8:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_en;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    mips_mem_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int a);
        logic [8:0] a9;
        a9 = a[8:0];
        if (a9 == 9'h004) return 32'h2008_0005;
        return {a9, 7'h11, ~a9, 7'h05};
    endfunction

    // Synchronous RAM seen by the arbiter
    logic [31:0] env_mem [512];
    logic        mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 512; i++) env_mem[i] <= init_val(i);
            mem_init_done <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) env_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= env_mem[mem_addr];
        end
    end

    logic [31:0] ref_mem [512];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        if_req = 1'b0;
        d_req  = 1'b0;
        reset  = 1'b1;
        next_cycle();
        reset  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, "_if_ack"}, if_ack, 1'b0);
        chk1({tag, "_d_ack"}, d_ack, 1'b0);
        chk32({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk32({tag, "_d_rdata"}, d_rdata, 32'h0);
        chk1({tag, "_mem_en"}, mem_en, 1'b0);
        chk1({tag, "_mem_we"}, mem_we, 1'b0);
        chk32({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_if_stall"}, if_stall, 1'b0);
        chk1({tag, "_d_stall"}, d_stall, 1'b0);
    endtask

    typedef struct {
        logic        is_data;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    // One isolated access starting in IDLE: request at T, issue at T+1, ack at T+2
    task automatic do_txn(input vec_t v);
        if (v.is_data) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        @(negedge clk);
        chk1("req_stall", v.is_data ? d_stall : if_stall, 1'b1);
        chk1("req_busy", busy, 1'b0);
        chk1("req_mem_en", mem_en, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("iss_mem_en", mem_en, 1'b1);
        chk1("iss_mem_we", mem_we, v.we);
        chk32("iss_mem_addr", 32'(mem_addr), 32'(v.addr));
        if (v.we) chk32("iss_mem_wdata", mem_wdata, v.wdata);
        chk1("iss_stall", v.is_data ? d_stall : if_stall, 1'b1);
        chk1("iss_busy", busy, 1'b1);
        chk1("iss_ack", if_ack | d_ack, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("ack_if", if_ack, !v.is_data);
        chk1("ack_d", d_ack, v.is_data);
        chk32("ack_if_rdata", if_rdata, v.is_data ? 32'h0 : v.exp_rdata);
        chk32("ack_d_rdata", d_rdata, v.is_data ? v.exp_rdata : 32'h0);
        chk1("ack_stall", if_stall | d_stall, 1'b0);
        chk1("ack_mem_en", mem_en, 1'b0);
        chk1("ack_busy", busy, 1'b1);
        if (v.we) ref_mem[v.addr] = v.wdata;
        next_cycle();
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        chk1("post_ack", if_ack | d_ack, 1'b0);
        chk1("post_busy", busy, 1'b0);
        next_cycle();
    endtask

    vec_t vecs [8];

    // transaction-level model state for the random phase
    int          cyc, iss_cyc, ack_cyc, next_free;
    bit          own_d, own_we, last_d, pick_d, f_drop, d_drop;
    logic [8:0]  own_addr;
    logic [31:0] own_wdata;
    bit          e_iss, e_ack, e_if_ack, e_d_ack;
    logic [31:0] e_if_rd, e_d_rd;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 9'h004, 32'h0,         32'h2008_0005};
        vecs[1] = '{1'b1, 1'b1, 9'h010, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 9'h010, 32'h0,         32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b0, 9'h010, 32'h0,         32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 1'b1, 9'h1FF, 32'h0000_1234, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 9'h1FF, 32'h0,         32'h0000_1234};
        vecs[6] = '{1'b1, 1'b0, 9'h000, 32'h0,         init_val(0)};
        vecs[7] = '{1'b0, 1'b0, 9'h1FF, 32'h0,         32'h0000_1234};
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);

        // reset held two cycles, then idle
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_all_zero("idle");
            next_cycle();
        end

        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // both requesters held continuously from T
        apply_reset();
        if_req = 1'b1; if_addr = 9'h008;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h00C;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("tie_d_ack", d_ack, (i == 2) || (i == 8) || (!RR && i == 5));
            chk1("tie_if_ack", if_ack, RR && i == 5);
            if (i == 2) chk32("tie_d_rdata", d_rdata, ref_mem[12]);
            if (RR && i == 5) chk32("tie_if_rdata", if_rdata, ref_mem[8]);
            next_cycle();
        end
        apply_reset();

        // reset during ISSUE of a fetch
        if_req = 1'b1; if_addr = 9'h014;
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk1("rst_mid_mem_en", mem_en, 1'b1);
        next_cycle();
        reset = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        next_cycle();
        @(negedge clk);
        chk1("rst_mid_no_ack", if_ack, 1'b0);
        next_cycle();
        do_txn('{1'b0, 1'b0, 9'h014, 32'h0, ref_mem[20]});

        // random traffic against the transaction model
        apply_reset();
        cyc = 0; iss_cyc = -1; ack_cyc = -1; next_free = 0;
        last_d = 1'b0; f_drop = 1'b0; d_drop = 1'b0; own_d = 1'b0; own_we = 1'b0;
        own_addr = '0; own_wdata = '0;
        for (int n = 0; n < 3000; n++) begin
            if (f_drop) begin
                if_req = 1'b0; f_drop = 1'b0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = 9'($urandom_range(0, 15));
            end
            if (d_drop) begin
                d_req = 1'b0; d_drop = 1'b0;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = 9'($urandom_range(0, 15)); d_wdata = $urandom;
            end
            @(negedge clk);
            e_iss    = (cyc == iss_cyc);
            e_ack    = (cyc == ack_cyc);
            e_if_ack = e_ack && !own_d;
            e_d_ack  = e_ack && own_d;
            e_if_rd  = e_if_ack ? ref_mem[own_addr] : 32'h0;
            e_d_rd   = (e_d_ack && !own_we) ? ref_mem[own_addr] : 32'h0;
            chk1("rnd_if_ack", if_ack, e_if_ack);
            chk1("rnd_d_ack", d_ack, e_d_ack);
            chk32("rnd_if_rdata", if_rdata, e_if_rd);
            chk32("rnd_d_rdata", d_rdata, e_d_rd);
            chk1("rnd_mem_en", mem_en, e_iss);
            chk1("rnd_busy", busy, e_iss || e_ack);
            chk1("rnd_if_stall", if_stall, if_req && !e_if_ack);
            chk1("rnd_d_stall", d_stall, d_req && !e_d_ack);
            if (e_iss) begin
                chk1("rnd_mem_we", mem_we, own_we);
                chk32("rnd_mem_addr", 32'(mem_addr), 32'(own_addr));
                if (own_we) chk32("rnd_mem_wdata", mem_wdata, own_wdata);
            end
            if (e_ack) begin
                if (own_we) ref_mem[own_addr] = own_wdata;
                if (own_d) d_drop = 1'b1;
                else       f_drop = 1'b1;
            end
            if (cyc >= next_free && (if_req || d_req)) begin
                pick_d    = d_req && (!if_req || !RR || !last_d);
                own_d     = pick_d;
                own_we    = pick_d && d_we;
                own_addr  = pick_d ? d_addr : if_addr;
                own_wdata = d_wdata;
                last_d    = pick_d;
                iss_cyc   = cyc + 1;
                ack_cyc   = cyc + 2;
                next_free = cyc + 3;
            end
            next_cycle();
            cyc++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
